// File: rtl/core_pkg.sv
// Shared definitions for the core control path: sequencer states, PC and
// writeback select codes, trap cause codes and decoder-side constants.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_e;

    // Next-PC source select
    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_ALU  = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_CSR = 2'b11;

    // Trap causes, RISC-V mcause encoding
    localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_INSN_FAULT      = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL         = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT      = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT     = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M         = 4'd11;

    // funct3 of ECALL/EBREAK within the SYSTEM opcode
    localparam logic [2:0] F3_PRIV = 3'b000;

    // Opcodes, ALU operations and operand selects used by the decoder
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    localparam logic [1:0] SEL_OPA_RS1  = 2'b00;
    localparam logic [1:0] SEL_OPA_PC   = 2'b01;
    localparam logic [1:0] SEL_OPA_ZERO = 2'b10;
    localparam logic       SEL_OPB_RS2  = 1'b0;
    localparam logic       SEL_OPB_IMM  = 1'b1;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus wait watchdog: counts cycles a request waits without a response and
// flags the limit cycle. Held at zero while no request is outstanding, so it
// restarts from zero on every entry into a bus wait state.
module bus_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic resp_i,
    output logic expired_o
);

    localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired_o = active_i & ~resp_i & (cnt_q == LAST);

    // Next count: clear when idle or expired, advance while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i) begin
            cnt_d = '0;
        end else if (resp_i || expired_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the single-issue core: fetch, decode, execute,
// memory access, writeback and synchronous traps. Strobes decode from the
// current state and inputs; only the trap cause is held in a register.
// Optional build macro BUS_TIMEOUT_EN adds a bus wait watchdog that traps a
// FETCH or MEM access left unanswered for TIMEOUT_CYCLES cycles.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       imem_req_o,
    input  logic       imem_ack_i,
    input  logic       imem_err_i,
    output logic       ir_we_o,
    input  logic       is_lui_i,
    input  logic       is_auipc_i,
    input  logic       is_jal_i,
    input  logic       is_jalr_i,
    input  logic       is_branch_i,
    input  logic       is_mem_i,
    input  logic       we_mem_i,
    input  logic       is_misc_mem_i,
    input  logic       is_system_i,
    input  logic       e_illegal_inst_i,
    input  logic [2:0] funct3_i,
    input  logic [4:0] rd_i,
    input  logic       sys_ebreak_i,
    input  logic       branch_taken_i,
    input  logic       addr_misaligned_i,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    input  logic       dmem_ack_i,
    input  logic       dmem_err_i,
    output logic       rf_we_o,
    output logic [1:0] rf_wsel_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       trap_o,
    output logic [3:0] trap_cause_o,
    output logic       retire_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("core_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    state_e     state_q, state_d;
    logic [3:0] cause_q, cause_d;
    logic       is_store_s, is_priv_s, is_jump_s, expired_s;

    assign is_store_s   = is_mem_i & we_mem_i;
    assign is_priv_s    = is_system_i & (funct3_i == F3_PRIV);
    assign is_jump_s    = is_jal_i | is_jalr_i | (is_branch_i & branch_taken_i);
    assign trap_cause_o = cause_q;

`ifdef BUS_TIMEOUT_EN
    logic wait_active_s, bus_resp_s;

    assign wait_active_s = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign bus_resp_s    = (state_q == ST_FETCH) ? (imem_ack_i | imem_err_i)
                                                 : (dmem_ack_i | dmem_err_i);

    bus_timeout_ctr #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_bus_timeout_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (wait_active_s),
        .resp_i    (bus_resp_s),
        .expired_o (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next state, next trap cause and all strobes from state plus inputs
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_o = 1'b0;
        ir_we_o    = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        rf_we_o    = 1'b0;
        rf_wsel_o  = WB_SEL_ALU;
        pc_we_o    = 1'b0;
        pc_sel_o   = PC_SEL_PC4;
        trap_o     = 1'b0;
        retire_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_err_i || (!imem_ack_i && expired_s)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_INSN_FAULT;
                end else if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (e_illegal_inst_i) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (is_mem_i && addr_misaligned_i) begin
                    state_d = ST_TRAP;
                    cause_d = we_mem_i ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                end else if (is_mem_i) begin
                    state_d = ST_MEM;
                end else if (is_priv_s) begin
                    state_d = ST_TRAP;
                    cause_d = sys_ebreak_i ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
                end else if (is_jump_s && addr_misaligned_i) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_INSN_MISALIGNED;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = we_mem_i;
                if (dmem_err_i || (!dmem_ack_i && expired_s)) begin
                    state_d = ST_TRAP;
                    cause_d = we_mem_i ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                end else if (dmem_ack_i) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                pc_we_o  = 1'b1;
                retire_o = 1'b1;
                pc_sel_o = is_jump_s ? PC_SEL_ALU : PC_SEL_PC4;
                rf_we_o  = ~(is_store_s | is_branch_i | is_misc_mem_i | is_priv_s |
                             (rd_i == 5'd0));
                if (is_mem_i) begin
                    rf_wsel_o = WB_SEL_MEM;
                end else if (is_jal_i || is_jalr_i) begin
                    rf_wsel_o = WB_SEL_PC4;
                end else if (is_system_i) begin
                    rf_wsel_o = WB_SEL_CSR;
                end else if (is_lui_i || is_auipc_i) begin
                    rf_wsel_o = WB_SEL_ALU;
                end else begin
                    rf_wsel_o = WB_SEL_ALU;
                end
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap_o   = 1'b1;
                pc_we_o  = 1'b1;
                pc_sel_o = PC_SEL_TRAP;
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and trap cause registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer. Each instruction pushes
// its expected outcome to a scoreboard; the entry is popped and compared
// when the DUT retires or traps.
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req, imem_ack = 1'b0, imem_err = 1'b0, ir_we;
    logic       dmem_req, dmem_we, dmem_ack = 1'b0, dmem_err = 1'b0;
    logic       rf_we, pc_we, trap, retire;
    logic [1:0] rf_wsel, pc_sel;
    logic [3:0] trap_cause;

    typedef struct packed {
        logic       lui, auipc, jal, jalr, branch, mem, we_mem, misc, sys, illegal;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       ebreak, taken, mis;
    } dec_t;

    typedef struct {
        bit         is_trap;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wsel;
        logic [3:0] cause;
        int         lat;
        int         ireq;
        int         dreq;
        logic       dwe;
    } exp_t;

    dec_t d = '0;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    core_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .imem_req_o(imem_req), .imem_ack_i(imem_ack), .imem_err_i(imem_err),
        .ir_we_o(ir_we),
        .is_lui_i(d.lui), .is_auipc_i(d.auipc), .is_jal_i(d.jal), .is_jalr_i(d.jalr),
        .is_branch_i(d.branch), .is_mem_i(d.mem), .we_mem_i(d.we_mem),
        .is_misc_mem_i(d.misc), .is_system_i(d.sys), .e_illegal_inst_i(d.illegal),
        .funct3_i(d.f3), .rd_i(d.rd), .sys_ebreak_i(d.ebreak),
        .branch_taken_i(d.taken), .addr_misaligned_i(d.mis),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err),
        .rf_we_o(rf_we), .rf_wsel_o(rf_wsel), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
        .trap_o(trap), .trap_cause_o(trap_cause), .retire_o(retire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_ret(logic [1:0] ps, logic we, logic [1:0] ws, int lat,
                                    int ireq, int dreq, logic dwe);
        exp_t e;
        e.is_trap = 1'b0; e.pc_sel = ps; e.rf_we = we; e.wsel = ws; e.cause = 4'd0;
        e.lat = lat; e.ireq = ireq; e.dreq = dreq; e.dwe = dwe;
        return e;
    endfunction

    function automatic exp_t mk_trap(logic [3:0] cause, int lat, int ireq, int dreq, logic dwe);
        exp_t e;
        e.is_trap = 1'b1; e.pc_sel = 2'b10; e.rf_we = 1'b0; e.wsel = 2'b00; e.cause = cause;
        e.lat = lat; e.ireq = ireq; e.dreq = dreq; e.dwe = dwe;
        return e;
    endfunction

    // Run one instruction: respond to bus requests after the given number of
    // wait cycles, then compare the retire/trap cycle against the scoreboard.
    task automatic run_instr(input string tag, input dec_t di, input int iwait, input bit ierr,
                             input int dwait, input bit derr, input exp_t e);
        exp_t x;
        int   cyc = 0, ireq = 0, dreq = 0, irwe = 0, iw = 0, dw = 0;
        bit   started = 1'b0, done = 1'b0, dwe_bad = 1'b0;
        sb_q.push_back(e);
        d = di;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
            if (imem_req) begin
                started = 1'b1;
                if (iw == iwait) begin
                    if (ierr) imem_err = 1'b1; else imem_ack = 1'b1;
                end
                iw++;
            end
            if (dmem_req) begin
                if (dw == dwait) begin
                    if (derr) dmem_err = 1'b1; else dmem_ack = 1'b1;
                end
                dw++;
            end
            @(negedge clk);
            if (started) cyc++;
            if (imem_req) ireq++;
            if (dmem_req) begin
                dreq++;
                if (dmem_we !== e.dwe) dwe_bad = 1'b1;
            end
            if (ir_we) irwe++;
            if (retire || trap) begin
                done = 1'b1;
                x = sb_q.pop_front();
                chk({tag, " trap"}, 32'(trap), 32'(x.is_trap));
                chk({tag, " retire"}, 32'(retire), 32'(!x.is_trap));
                chk({tag, " pc_we"}, 32'(pc_we), 32'd1);
                chk({tag, " pc_sel"}, 32'(pc_sel), 32'(x.pc_sel));
                chk({tag, " rf_we"}, 32'(rf_we), 32'(x.rf_we));
                if (x.is_trap) chk({tag, " cause"}, 32'(trap_cause), 32'(x.cause));
                else chk({tag, " rf_wsel"}, 32'(rf_wsel), 32'(x.wsel));
                chk({tag, " latency"}, 32'(cyc), 32'(x.lat));
                chk({tag, " imem_req cycles"}, 32'(ireq), 32'(x.ireq));
                chk({tag, " dmem_req cycles"}, 32'(dreq), 32'(x.dreq));
                chk({tag, " dmem_we"}, 32'(dwe_bad), 32'd0);
                chk({tag, " ir_we count"}, 32'(irwe), 32'((x.cause == 4'd1 && x.is_trap) ? 0 : 1));
            end
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $error("FAIL %s timeout: observed=no retire/trap expected=retire/trap", tag);
            void'(sb_q.pop_front());
        end
    endtask

    // Directed sequence
    initial begin
        int hi;
        // Reset state
        @(negedge clk); @(negedge clk);
        chk("reset outputs", {imem_req, ir_we, dmem_req, dmem_we, rf_we, rf_wsel, pc_we, pc_sel,
                              trap, trap_cause, retire}, 32'd0);
        rst_n = 1'b1;
        #1 chk("idle after release", 32'(imem_req), 32'd0);

        d = '0; d.rd = 5'd5;
        run_instr("ADD x5", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b1, 2'b00, 4, 1, 0, 1'b0));
        d = '0; d.mem = 1'b1; d.rd = 5'd6;
        run_instr("LW x6", d, 0, 0, 3, 0, mk_ret(2'b00, 1'b1, 2'b01, 8, 1, 4, 1'b0));
        d = '0; d.illegal = 1'b1; d.rd = 5'd4;
        run_instr("illegal", d, 0, 0, 0, 0, mk_trap(4'd2, 3, 1, 0, 1'b0));
        d = '0; d.branch = 1'b1; d.taken = 1'b1; d.rd = 5'd3;
        run_instr("BEQ taken", d, 0, 0, 0, 0, mk_ret(2'b01, 1'b0, 2'b00, 4, 1, 0, 1'b0));
        d = '0; d.branch = 1'b1; d.rd = 5'd3;
        run_instr("BEQ not taken", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b0, 2'b00, 4, 1, 0, 1'b0));
        d = '0; d.mem = 1'b1; d.we_mem = 1'b1; d.mis = 1'b1; d.rd = 5'd8;
        run_instr("SW misaligned", d, 0, 0, 0, 0, mk_trap(4'd6, 4, 1, 0, 1'b1));
        d = '0; d.sys = 1'b1;
        run_instr("ECALL", d, 0, 0, 0, 0, mk_trap(4'd11, 4, 1, 0, 1'b0));
        @(negedge clk);
        chk("cause hold", 32'(trap_cause), 32'd11);
        d = '0; d.sys = 1'b1; d.ebreak = 1'b1;
        run_instr("EBREAK", d, 0, 0, 0, 0, mk_trap(4'd3, 4, 1, 0, 1'b0));
        d = '0; d.jal = 1'b1; d.rd = 5'd1;
        run_instr("JAL x1 iwait2", d, 2, 0, 0, 0, mk_ret(2'b01, 1'b1, 2'b10, 6, 3, 0, 1'b0));
        d = '0; d.mem = 1'b1; d.we_mem = 1'b1; d.rd = 5'd9;
        run_instr("SW", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b0, 2'b01, 5, 1, 1, 1'b1));
        d = '0; d.sys = 1'b1; d.f3 = 3'd1; d.rd = 5'd7;
        run_instr("CSRRW x7", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b1, 2'b11, 4, 1, 0, 1'b0));
        d = '0; d.mem = 1'b1; d.mis = 1'b1; d.rd = 5'd2;
        run_instr("LW misaligned", d, 0, 0, 0, 0, mk_trap(4'd4, 4, 1, 0, 1'b0));
        d = '0; d.mem = 1'b1; d.rd = 5'd2;
        run_instr("LW bus err", d, 0, 0, 1, 1, mk_trap(4'd5, 6, 1, 2, 1'b0));
        d = '0; d.mem = 1'b1; d.we_mem = 1'b1; d.rd = 5'd2;
        run_instr("SW bus err", d, 0, 0, 0, 1, mk_trap(4'd7, 5, 1, 1, 1'b1));
        d = '0; d.rd = 5'd2;
        run_instr("fetch err", d, 1, 1, 0, 0, mk_trap(4'd1, 3, 2, 0, 1'b0));
        d = '0; d.jalr = 1'b1; d.mis = 1'b1; d.rd = 5'd1;
        run_instr("JALR misaligned", d, 0, 0, 0, 0, mk_trap(4'd0, 4, 1, 0, 1'b0));
        d = '0; d.branch = 1'b1; d.mis = 1'b1;
        run_instr("BEQ nt misaligned", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b0, 2'b00, 4, 1, 0, 1'b0));
        d = '0; d.misc = 1'b1; d.rd = 5'd5;
        run_instr("FENCE", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b0, 2'b00, 4, 1, 0, 1'b0));
        d = '0; d.lui = 1'b1; d.rd = 5'd10;
        run_instr("LUI x10", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b1, 2'b00, 4, 1, 0, 1'b0));

        // Reset in the middle of a memory access
        d = '0; d.mem = 1'b1; d.rd = 5'd6;
        hi = 0;
        for (int k = 0; k < 20 && !dmem_req; k++) begin
            @(posedge clk); #1;
            imem_ack = imem_req;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("in MEM before reset", 32'(dmem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("reset drops dmem_req", 32'({dmem_req, imem_req, trap_cause}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle after mid reset", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("fetch resumes", 32'(imem_req), 32'd1);
        d = '0; d.rd = 5'd0;
        run_instr("ADDI x0", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b0, 2'b00, 4, 1, 0, 1'b0));

        // Unanswered instruction fetch
        d = '0; d.rd = 5'd5;
`ifdef BUS_TIMEOUT_EN
        run_instr("fetch timeout", d, 1000, 0, 0, 0, mk_trap(4'd1, 17, 16, 0, 1'b0));
`else
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (imem_req) hi++;
        end
        chk("fetch waits forever", 32'(hi), 32'd110);
        run_instr("ADD after wait", d, 0, 0, 0, 0, mk_ret(2'b00, 1'b1, 2'b00, 4, 1, 0, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the single-issue core. It fetches an instruction, latches it for the decoder and consumes the decoder's class flags. It then sequences the ALU/memory/writeback datapath and raises synchronous traps. It owns all PC, register-file and data-bus strobes.

Parameters:
TIMEOUT_CYCLES, 16, bus wait limit in cycles; used only when BUS_TIMEOUT_EN is defined; legal range ≥2.

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-low reset
imem_req_o / imem_ack_i / imem_err_i  out/in/in  1  instruction bus handshake
ir_we_o  out  1  instruction register load strobe
is_lui_i, is_auipc_i, is_jal_i, is_jalr_i, is_branch_i, is_mem_i, we_mem_i, is_misc_mem_i, is_system_i, e_illegal_inst_i  in  1 each  decoder flags
funct3_i  in  3  decoder funct3
rd_i  in  5  destination register
sys_ebreak_i  in  1  instruction bit 20; 1 = EBREAK when SYSTEM and funct3=0
branch_taken_i  in  1  ALU compare result
addr_misaligned_i  in  1  ALU result misaligned for current access/target
dmem_req_o / dmem_we_o / dmem_ack_i / dmem_err_i  out/out/in/in  1  data bus handshake
rf_we_o  out  1  register-file write enable
rf_wsel_o  out  2  00 ALU, 01 MEM, 10 PC+4, 11 CSR
pc_we_o  out  1  PC update strobe
pc_sel_o  out  2  00 PC+4, 01 ALU target, 10 trap vector
trap_o  out  1  one-cycle trap pulse
trap_cause_o  out  4  registered cause code (RISC-V mcause encoding)
retire_o  out  1  one-cycle instruction retire pulse

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Outputs decode from state plus current inputs.
- Reset (rst_i=0, async): state IDLE; all outputs 0; trap_cause_o=0. Mid-operation reset drops imem_req_o/dmem_req_o immediately.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: imem_req_o=1 until response.
  - err (wins over ack): go to TRAP, cause 1.
  - ack: ir_we_o=1 for that cycle, go to DECODE.
- DECODE: one cycle.
  - e_illegal_inst_i: go to TRAP, cause 2.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - is_mem_i with addr_misaligned_i: go to TRAP, cause 4 (load) or 6 (store).
  - is_mem_i otherwise: go to MEM.
  - is_system_i with funct3_i=0: go to TRAP, cause 3 if sys_ebreak_i, else 11.
  - jal/jalr/taken branch with addr_misaligned_i: go to TRAP, cause 0.
  - Otherwise go to WB.
- MEM: dmem_req_o=1, dmem_we_o=we_mem_i, both held until response.
  - err (wins): go to TRAP, cause 5 (load) or 7 (store).
  - ack: go to WB.
- WB: pc_we_o=1, retire_o=1, then go to FETCH.
  - pc_sel_o=01 for jal, jalr, or branch with branch_taken_i; else 00.
  - rf_we_o=1 unless store, branch, misc_mem, ECALL/EBREAK, or rd_i=0.
  - rf_wsel_o: load 01, jal/jalr 10, CSR 11, else 00.
  - MISC_MEM executes as a no-op.
- TRAP: trap_o=1, pc_we_o=1, pc_sel_o=10; trap_cause_o updates this cycle and holds; no rf_we_o, no retire_o; then go to FETCH.
- Latency, zero-wait bus: ALU/jump/branch 4 cycles; load/store 5 cycles; each wait cycle adds 1.
- Decoder inputs are sampled only in DECODE, EXECUTE, MEM and WB; values in other states are ignored.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter clears on entry to FETCH/MEM and increments each cycle without ack/err.
  - Reaching TIMEOUT_CYCLES-1 with no response: drop the request and go to TRAP, cause 1 (FETCH) or 5/7 (MEM).
  - A response arriving in the limit cycle is honoured normally.
- Undefined: FETCH/MEM wait indefinitely; no counter logic present.

Decomposition:
- Shared package core_pkg holds:
  - state enum;
  - PC_SEL_* and WB_SEL_* constants;
  - CAUSE_* codes (0,1,2,3,4,5,6,7,11);
  - opcode/ALU/SEL_* constants already used by the decoder.
- Sub-module bus_timeout_ctr (counter + expiry flag) is instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- ADD x5 with acks in the same cycle as req: ir_we_o at cycle 1; retire_o, rf_we_o=1, rf_wsel_o=00, pc_sel_o=00 at cycle 4.
- LW x6 with dmem_ack_i 3 cycles late: dmem_req_o high 4 cycles, dmem_we_o=0; WB rf_wsel_o=01; retire 8 cycles after fetch start.
- Illegal opcode, then BEQ taken, then BEQ not taken:
  - illegal → trap_o one cycle, trap_cause_o=2, pc_sel_o=10, no retire;
  - BEQ taken → pc_sel_o=01, rf_we_o=0;
  - BEQ not taken → pc_sel_o=00.
- SW with addr_misaligned_i=1: dmem_req_o never asserted; trap_cause_o=6. ECALL gives trap_cause_o=11; EBREAK gives 3.
- rst_i low mid-MEM: dmem_req_o=0 same cycle; state IDLE; FETCH resumes 1 cycle after release. ADDI x0 retires with rf_we_o=0.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem never acks: imem_req_o high 16 cycles, then trap_cause_o=1. With the macro undefined, req stays high for more than 100 cycles.
